// File: rtl/rs_operand_wakeup_pkg.sv
// Shared widths, the "no producer" tag value and the CDB channel-slice helper
// for the reservation-station operand-wakeup block.
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 6
`endif

`ifndef RS_CDB_SLICE
`define RS_CDB_SLICE(bus, k, w) bus[(k)*(w) +: (w)]
`endif

package rs_operand_wakeup_pkg;

  localparam int unsigned RobEntryWidth = `ROB_ENTRY_WIDTH;
  localparam int unsigned XlenDef       = 32;
  // A tag of zero means the operand value is already present.
  localparam int unsigned TagNone       = 0;

endpackage

// File: rtl/rs_operand_wakeup_if.sv
// Dispatch, CDB snoop and issue signals of the reservation station.
// The slave modport is the station itself; master is the surrounding pipeline.
interface rs_operand_wakeup_if
  import rs_operand_wakeup_pkg::*;
#(
  parameter int unsigned NUM_CDB = 3,
  parameter int unsigned XLEN    = XlenDef,
  parameter int unsigned ROB_W   = RobEntryWidth,
  parameter int unsigned OP_W    = 8
);

  logic                     disp_valid;
  logic                     disp_ready;
  logic [OP_W-1:0]          disp_op;
  logic [ROB_W-1:0]         disp_dest;
  logic [XLEN-1:0]          disp_a_val;
  logic [ROB_W-1:0]         disp_a_tag;
  logic [XLEN-1:0]          disp_b_val;
  logic [ROB_W-1:0]         disp_b_tag;
  logic [NUM_CDB*ROB_W-1:0] cdb_rob_index;
  logic [NUM_CDB*XLEN-1:0]  cdb_data;
  logic                     issue_valid;
  logic                     issue_ready;
  logic [OP_W-1:0]          issue_op;
  logic [ROB_W-1:0]         issue_dest;
  logic [XLEN-1:0]          issue_a;
  logic [XLEN-1:0]          issue_b;

  modport slave (
    input  disp_valid, disp_op, disp_dest, disp_a_val, disp_a_tag, disp_b_val, disp_b_tag,
    output disp_ready,
    input  cdb_rob_index, cdb_data,
    output issue_valid, issue_op, issue_dest, issue_a, issue_b,
    input  issue_ready
  );

  modport master (
    output disp_valid, disp_op, disp_dest, disp_a_val, disp_a_tag, disp_b_val, disp_b_tag,
    input  disp_ready,
    output cdb_rob_index, cdb_data,
    input  issue_valid, issue_op, issue_dest, issue_a, issue_b,
    output issue_ready
  );

endinterface

// File: rtl/rs_cdb_match.sv
// Compares one operand tag against every CDB channel; the lowest-numbered
// matching channel supplies the data. A zero tag never matches.
module rs_cdb_match
  import rs_operand_wakeup_pkg::*;
#(
  parameter int unsigned NUM_CDB = 3,
  parameter int unsigned XLEN    = XlenDef,
  parameter int unsigned ROB_W   = RobEntryWidth
) (
  input  logic [ROB_W-1:0]         i_tag,
  input  logic [NUM_CDB*ROB_W-1:0] i_cdb_idx,
  input  logic [NUM_CDB*XLEN-1:0]  i_cdb_data,
  output logic                     o_hit,
  output logic [XLEN-1:0]          o_data
);

  localparam logic [ROB_W-1:0] TagZero = ROB_W'(TagNone);

  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (!o_hit && (i_tag != TagZero) && (`RS_CDB_SLICE(i_cdb_idx, k, ROB_W) == i_tag)) begin
        o_hit  = 1'b1;
        o_data = `RS_CDB_SLICE(i_cdb_data, k, XLEN);
      end
    end
  end

endmodule

// File: rtl/rs_operand_wakeup.sv
// Reservation station: holds dispatched micro-ops, captures pending operands
// from the CDB and issues the lowest-index ready entry to one functional unit.
module rs_operand_wakeup
  import rs_operand_wakeup_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned NUM_CDB = 3,
  parameter int unsigned XLEN    = XlenDef,
  parameter int unsigned ROB_W   = RobEntryWidth,
  parameter int unsigned OP_W    = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  rs_operand_wakeup_if.slave         io_rs
);

  localparam int unsigned      IDX_W   = $clog2(DEPTH);
  localparam int unsigned      CNT_W   = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);
  localparam logic [ROB_W-1:0] TagZero = ROB_W'(TagNone);

  logic [DEPTH-1:0] r_valid;
  logic [OP_W-1:0]  r_op    [DEPTH];
  logic [ROB_W-1:0] r_dest  [DEPTH];
  logic [XLEN-1:0]  r_a_val [DEPTH];
  logic [ROB_W-1:0] r_a_tag [DEPTH];
  logic [XLEN-1:0]  r_b_val [DEPTH];
  logic [ROB_W-1:0] r_b_tag [DEPTH];

  logic [DEPTH-1:0] w_a_hit, w_b_hit, w_ready;
  logic [XLEN-1:0]  w_a_data [DEPTH];
  logic [XLEN-1:0]  w_b_data [DEPTH];
  logic             w_da_hit, w_db_hit;
  logic [XLEN-1:0]  w_da_data, w_db_data;
  logic             w_free_found, w_ready_found;
  logic [IDX_W-1:0] w_free_idx, w_issue_idx;
  logic [CNT_W-1:0] w_count;
  logic             w_disp_fire, w_issue_fire;

  // Same-cycle bypass for operands arriving with dispatch.
  rs_cdb_match #(.NUM_CDB(NUM_CDB), .XLEN(XLEN), .ROB_W(ROB_W)) u_disp_a_match (
    .i_tag      (io_rs.disp_a_tag),
    .i_cdb_idx  (io_rs.cdb_rob_index),
    .i_cdb_data (io_rs.cdb_data),
    .o_hit      (w_da_hit),
    .o_data     (w_da_data)
  );

  rs_cdb_match #(.NUM_CDB(NUM_CDB), .XLEN(XLEN), .ROB_W(ROB_W)) u_disp_b_match (
    .i_tag      (io_rs.disp_b_tag),
    .i_cdb_idx  (io_rs.cdb_rob_index),
    .i_cdb_data (io_rs.cdb_data),
    .o_hit      (w_db_hit),
    .o_data     (w_db_data)
  );

  for (genvar g = 0; g < DEPTH; g++) begin : g_wake
    rs_cdb_match #(.NUM_CDB(NUM_CDB), .XLEN(XLEN), .ROB_W(ROB_W)) u_a_match (
      .i_tag      (r_a_tag[g]),
      .i_cdb_idx  (io_rs.cdb_rob_index),
      .i_cdb_data (io_rs.cdb_data),
      .o_hit      (w_a_hit[g]),
      .o_data     (w_a_data[g])
    );

    rs_cdb_match #(.NUM_CDB(NUM_CDB), .XLEN(XLEN), .ROB_W(ROB_W)) u_b_match (
      .i_tag      (r_b_tag[g]),
      .i_cdb_idx  (io_rs.cdb_rob_index),
      .i_cdb_data (io_rs.cdb_data),
      .o_hit      (w_b_hit[g]),
      .o_data     (w_b_data[g])
    );

    assign w_ready[g] = r_valid[g] && (r_a_tag[g] == TagZero) && (r_b_tag[g] == TagZero);
  end

  always_comb begin
    w_free_found  = 1'b0;
    w_free_idx    = '0;
    w_ready_found = 1'b0;
    w_issue_idx   = '0;
    w_count       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_free_found && !r_valid[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
      if (!w_ready_found && w_ready[i]) begin
        w_ready_found = 1'b1;
        w_issue_idx   = IDX_W'(i);
      end
      w_count = w_count + CNT_W'(r_valid[i]);
    end
  end

  // A freed slot only becomes reusable after the edge, so readiness ignores issue.
  assign io_rs.disp_ready = w_free_found;
  assign w_disp_fire      = io_rs.disp_valid && w_free_found;
  assign w_issue_fire     = w_ready_found && io_rs.issue_ready;
  assign o_count          = w_count;

  always_comb begin
    io_rs.issue_valid = w_ready_found;
    io_rs.issue_op    = '0;
    io_rs.issue_dest  = '0;
    io_rs.issue_a     = '0;
    io_rs.issue_b     = '0;
    if (w_ready_found) begin
      io_rs.issue_op   = r_op[w_issue_idx];
      io_rs.issue_dest = r_dest[w_issue_idx];
      io_rs.issue_a    = r_a_val[w_issue_idx];
      io_rs.issue_b    = r_b_val[w_issue_idx];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_valid[i] && w_a_hit[i]) begin
          r_a_val[i] <= w_a_data[i];
          r_a_tag[i] <= TagZero;
        end
        if (r_valid[i] && w_b_hit[i]) begin
          r_b_val[i] <= w_b_data[i];
          r_b_tag[i] <= TagZero;
        end
      end
      if (w_issue_fire) begin
        r_valid[w_issue_idx] <= 1'b0;
      end
      if (w_disp_fire) begin
        r_valid[w_free_idx] <= 1'b1;
        r_op[w_free_idx]    <= io_rs.disp_op;
        r_dest[w_free_idx]  <= io_rs.disp_dest;
        r_a_val[w_free_idx] <= w_da_hit ? w_da_data : io_rs.disp_a_val;
        r_a_tag[w_free_idx] <= w_da_hit ? TagZero : io_rs.disp_a_tag;
        r_b_val[w_free_idx] <= w_db_hit ? w_db_data : io_rs.disp_b_val;
        r_b_tag[w_free_idx] <= w_db_hit ? TagZero : io_rs.disp_b_tag;
      end
    end
  end

  a_disp_dest_nz: assert property (@(posedge i_clk) disable iff (i_rst || i_flush)
    w_disp_fire |-> (io_rs.disp_dest != TagZero));

  a_disp_not_full: assert property (@(posedge i_clk) disable iff (i_rst || i_flush)
    w_disp_fire |-> (w_count < FullCnt));

  a_count_bound: assert property (@(posedge i_clk) w_count <= FullCnt);

endmodule

// File: tb/tb_rs_operand_wakeup.sv
// Randomized and directed bench for rs_operand_wakeup against a behavioural
// model of the station's entry table.
module tb_rs_operand_wakeup;
  import rs_operand_wakeup_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned NUM_CDB = 3;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned ROB_W   = RobEntryWidth;
  localparam int unsigned OP_W    = 8;
  localparam int unsigned CNT_W   = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [CNT_W-1:0] count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [ROB_W-1:0] c_idx [NUM_CDB];
  logic [XLEN-1:0]  c_dat [NUM_CDB];

  // Model table.
  bit               m_valid [DEPTH];
  logic [OP_W-1:0]  m_op    [DEPTH];
  logic [ROB_W-1:0] m_dest  [DEPTH];
  logic [XLEN-1:0]  m_a     [DEPTH];
  logic [ROB_W-1:0] m_at    [DEPTH];
  logic [XLEN-1:0]  m_b     [DEPTH];
  logic [ROB_W-1:0] m_bt    [DEPTH];

  always #5 clk = ~clk;

  rs_operand_wakeup_if #(.NUM_CDB(NUM_CDB), .XLEN(XLEN), .ROB_W(ROB_W), .OP_W(OP_W)) bus ();

  rs_operand_wakeup #(
    .DEPTH   (DEPTH),
    .NUM_CDB (NUM_CDB),
    .XLEN    (XLEN),
    .ROB_W   (ROB_W),
    .OP_W    (OP_W)
  ) u_dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (flush),
    .o_count (count),
    .io_rs   (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int m_ready_slot();
    for (int i = 0; i < DEPTH; i++)
      if (m_valid[i] && m_at[i] == 0 && m_bt[i] == 0) return i;
    return -1;
  endfunction

  function automatic int m_occupancy();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_valid[i]);
    return n;
  endfunction

  task automatic lookup(input logic [ROB_W-1:0] tag, output bit hit, output logic [XLEN-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (tag != 0)
      for (int k = 0; k < NUM_CDB; k++)
        if (!hit && c_idx[k] == tag) begin
          hit = 1'b1;
          d   = c_dat[k];
        end
  endtask

  task automatic set_idle();
    rst = 1'b0;
    flush = 1'b0;
    bus.disp_valid = 1'b0;
    bus.disp_op = '0;
    bus.disp_dest = ROB_W'(1);
    bus.disp_a_val = '0;
    bus.disp_a_tag = '0;
    bus.disp_b_val = '0;
    bus.disp_b_tag = '0;
    bus.issue_ready = 1'b0;
    for (int k = 0; k < NUM_CDB; k++) begin
      c_idx[k] = '0;
      c_dat[k] = '0;
    end
  endtask

  task automatic set_disp(input logic [XLEN-1:0] a, input logic [ROB_W-1:0] at,
                          input logic [XLEN-1:0] b, input logic [ROB_W-1:0] bt,
                          input logic [ROB_W-1:0] dest);
    bus.disp_valid = 1'b1;
    bus.disp_op    = OP_W'(dest) ^ 8'h5A;
    bus.disp_dest  = dest;
    bus.disp_a_val = a;
    bus.disp_a_tag = at;
    bus.disp_b_val = b;
    bus.disp_b_tag = bt;
  endtask

  task automatic rand_inputs();
    set_idle();
    rst   = ($urandom_range(0, 99) == 0);
    flush = ($urandom_range(0, 59) == 0);
    bus.disp_valid = ($urandom_range(0, 99) < 60);
    bus.disp_op    = OP_W'($urandom);
    bus.disp_dest  = ROB_W'($urandom_range(1, (1 << ROB_W) - 1));
    bus.disp_a_val = $urandom;
    bus.disp_a_tag = ($urandom_range(0, 1) == 1) ? ROB_W'($urandom_range(1, 7)) : '0;
    bus.disp_b_val = $urandom;
    bus.disp_b_tag = ($urandom_range(0, 1) == 1) ? ROB_W'($urandom_range(1, 7)) : '0;
    bus.issue_ready = ($urandom_range(0, 99) < 55);
    for (int k = 0; k < NUM_CDB; k++) begin
      c_idx[k] = ($urandom_range(0, 2) == 0) ? ROB_W'($urandom_range(1, 7)) : '0;
      c_dat[k] = $urandom;
    end
  endtask

  // Called at a falling edge with inputs set; checks outputs, steps the model, advances a cycle.
  task automatic cycle();
    int ri, n, free;
    bit hit;
    logic [XLEN-1:0] d;
    for (int k = 0; k < NUM_CDB; k++) begin
      bus.cdb_rob_index[k*ROB_W +: ROB_W] = c_idx[k];
      bus.cdb_data[k*XLEN +: XLEN]        = c_dat[k];
    end
    #1;
    ri = m_ready_slot();
    n  = m_occupancy();
    check_eq("count", 64'(count), 64'(n));
    check_eq("disp_ready", 64'(bus.disp_ready), 64'(n < DEPTH));
    check_eq("issue_valid", 64'(bus.issue_valid), 64'(ri >= 0));
    check_eq("issue_op", 64'(bus.issue_op), (ri >= 0) ? 64'(m_op[ri]) : 64'(0));
    check_eq("issue_dest", 64'(bus.issue_dest), (ri >= 0) ? 64'(m_dest[ri]) : 64'(0));
    check_eq("issue_a", 64'(bus.issue_a), (ri >= 0) ? 64'(m_a[ri]) : 64'(0));
    check_eq("issue_b", 64'(bus.issue_b), (ri >= 0) ? 64'(m_b[ri]) : 64'(0));

    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    end else begin
      free = -1;
      for (int i = 0; i < DEPTH; i++) if (free < 0 && !m_valid[i]) free = i;
      for (int i = 0; i < DEPTH; i++) begin
        if (m_valid[i]) begin
          lookup(m_at[i], hit, d);
          if (hit) begin m_a[i] = d; m_at[i] = '0; end
          lookup(m_bt[i], hit, d);
          if (hit) begin m_b[i] = d; m_bt[i] = '0; end
        end
      end
      if (ri >= 0 && bus.issue_ready) m_valid[ri] = 1'b0;
      if (bus.disp_valid && free >= 0) begin
        m_valid[free] = 1'b1;
        m_op[free]    = bus.disp_op;
        m_dest[free]  = bus.disp_dest;
        lookup(bus.disp_a_tag, hit, d);
        m_a[free]  = hit ? d : bus.disp_a_val;
        m_at[free] = hit ? '0 : bus.disp_a_tag;
        lookup(bus.disp_b_tag, hit, d);
        m_b[free]  = hit ? d : bus.disp_b_val;
        m_bt[free] = hit ? '0 : bus.disp_b_tag;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    set_idle();
    bus.issue_ready = 1'b1;
    repeat (DEPTH + 1) cycle();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0; m_op[i] = '0; m_dest[i] = '0;
      m_a[i] = '0; m_at[i] = '0; m_b[i] = '0; m_bt[i] = '0;
    end
    set_idle();
    rst = 1'b1;
    @(negedge clk);
    cycle();
    cycle();

    // Ready-at-dispatch entry issues the following cycle.
    set_idle();
    set_disp(32'd5, '0, 32'd7, '0, ROB_W'(3));
    cycle();
    check_eq("tp1_valid", 64'(bus.issue_valid), 64'(1));
    check_eq("tp1_a", 64'(bus.issue_a), 64'(5));
    check_eq("tp1_b", 64'(bus.issue_b), 64'(7));
    check_eq("tp1_dest", 64'(bus.issue_dest), 64'(3));
    set_idle();
    bus.issue_ready = 1'b1;
    cycle();
    check_eq("tp1_count", 64'(count), 64'(0));

    // Wakeup two cycles after dispatch.
    set_idle();
    set_disp(32'd0, ROB_W'(4), 32'd9, '0, ROB_W'(9));
    cycle();
    set_idle();
    cycle();
    check_eq("tp2_wait", 64'(bus.issue_valid), 64'(0));
    c_idx[1] = ROB_W'(4);
    c_dat[1] = 32'hAA;
    cycle();
    check_eq("tp2_valid", 64'(bus.issue_valid), 64'(1));
    check_eq("tp2_a", 64'(bus.issue_a), 64'hAA);
    drain();

    // Dispatch-time bypass.
    set_idle();
    set_disp(32'd1, '0, 32'd0, ROB_W'(6), ROB_W'(10));
    c_idx[0] = ROB_W'(6);
    c_dat[0] = 32'h55;
    cycle();
    check_eq("tp3_valid", 64'(bus.issue_valid), 64'(1));
    check_eq("tp3_b", 64'(bus.issue_b), 64'h55);
    drain();

    // Lowest channel wins; idle channel with data never matches.
    set_idle();
    set_disp(32'd0, ROB_W'(2), 32'd0, '0, ROB_W'(11));
    cycle();
    set_idle();
    c_idx[0] = ROB_W'(2); c_dat[0] = 32'd1;
    c_idx[1] = '0;        c_dat[1] = 32'hFF;
    c_idx[2] = ROB_W'(2); c_dat[2] = 32'd3;
    cycle();
    check_eq("tp4_a", 64'(bus.issue_a), 64'(1));
    drain();

    // Flush with pending match clears everything.
    for (int i = 0; i < 3; i++) begin
      set_idle();
      set_disp(32'd0, ROB_W'(5), 32'd0, '0, ROB_W'(12 + i));
      cycle();
    end
    set_idle();
    flush = 1'b1;
    c_idx[0] = ROB_W'(5);
    c_dat[0] = 32'h77;
    cycle();
    check_eq("flush_count", 64'(count), 64'(0));
    check_eq("flush_issue", 64'(bus.issue_valid), 64'(0));
    check_eq("flush_ready", 64'(bus.disp_ready), 64'(1));

    repeat (1500) begin
      rand_inputs();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
